// File: rtl/id_ex_hazard_reg_if.sv
// ID/EX pipeline bundle: ID-stage operands and control in, registered EX-stage copies
// plus the load-use stall request out.
interface id_ex_hazard_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  logic              valid_id;
  logic [4:0]        rs1_id;
  logic [4:0]        rs2_id;
  logic [4:0]        rd_id;
  logic              uses_rs1_id;
  logic              uses_rs2_id;
  logic              reg_write_id;
  logic              mem_read_id;
  logic [CTRL_W-1:0] ctrl_id;
  logic [DATA_W-1:0] rdata1_id;
  logic [DATA_W-1:0] rdata2_id;
  logic [DATA_W-1:0] imm_id;
  logic [DATA_W-1:0] pc_id;
  logic              hold;
  logic              flush_ex;

  logic              valid_ex;
  logic [4:0]        rs1_ex;
  logic [4:0]        rs2_ex;
  logic [4:0]        rd_ex;
  logic              reg_write_ex;
  logic              mem_read_ex;
  logic [CTRL_W-1:0] ctrl_ex;
  logic [DATA_W-1:0] rdata1_ex;
  logic [DATA_W-1:0] rdata2_ex;
  logic [DATA_W-1:0] imm_ex;
  logic [DATA_W-1:0] pc_ex;
  logic              stall_id;

  modport master (
    output valid_id, rs1_id, rs2_id, rd_id, uses_rs1_id, uses_rs2_id,
           reg_write_id, mem_read_id, ctrl_id, rdata1_id, rdata2_id,
           imm_id, pc_id, hold, flush_ex,
    input  valid_ex, rs1_ex, rs2_ex, rd_ex, reg_write_ex, mem_read_ex,
           ctrl_ex, rdata1_ex, rdata2_ex, imm_ex, pc_ex, stall_id
  );

  modport slave (
    input  valid_id, rs1_id, rs2_id, rd_id, uses_rs1_id, uses_rs2_id,
           reg_write_id, mem_read_id, ctrl_id, rdata1_id, rdata2_id,
           imm_id, pc_id, hold, flush_ex,
    output valid_ex, rs1_ex, rs2_ex, rd_ex, reg_write_ex, mem_read_ex,
           ctrl_ex, rdata1_ex, rdata2_ex, imm_ex, pc_ex, stall_id
  );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble/flush insertion.
// Define ID_EX_STALL_CNT_EN to add free-running stall/flush bubble counters.
module id_ex_hazard_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic               clk,
  input  logic               arst_n,
  id_ex_hazard_reg_if.slave  bus
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              reg_write;
    logic              mem_read;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
  } ex_t;

  ex_t  ex_q;
  ex_t  ex_d;
  logic haz_s;
  logic stall_s;

  // Hazard detection and next EX contents; a bubble is an all-zero entry
  always_comb begin
    ex_d    = ex_q;
    haz_s   = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & bus.valid_id &
              ((bus.uses_rs1_id & (bus.rs1_id == ex_q.rd)) |
               (bus.uses_rs2_id & (bus.rs2_id == ex_q.rd)));
    stall_s = haz_s & ~bus.flush_ex & ~bus.hold;
    if (bus.hold) begin
      ex_d = ex_q;
    end else if (bus.flush_ex || haz_s) begin
      ex_d = '0;
    end else begin
      ex_d.valid     = bus.valid_id;
      ex_d.rs1       = bus.rs1_id;
      ex_d.rs2       = bus.rs2_id;
      ex_d.rd        = bus.valid_id ? bus.rd_id : 5'd0;
      ex_d.reg_write = bus.valid_id & bus.reg_write_id;
      ex_d.mem_read  = bus.valid_id & bus.mem_read_id;
      ex_d.ctrl      = bus.ctrl_id;
      ex_d.rdata1    = bus.rdata1_id;
      ex_d.rdata2    = bus.rdata2_id;
      ex_d.imm       = bus.imm_id;
      ex_d.pc        = bus.pc_id;
    end
  end

  // EX-stage register
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.valid_ex     = ex_q.valid;
  assign bus.rs1_ex       = ex_q.rs1;
  assign bus.rs2_ex       = ex_q.rs2;
  assign bus.rd_ex        = ex_q.rd;
  assign bus.reg_write_ex = ex_q.reg_write;
  assign bus.mem_read_ex  = ex_q.mem_read;
  assign bus.ctrl_ex      = ex_q.ctrl;
  assign bus.rdata1_ex    = ex_q.rdata1;
  assign bus.rdata2_ex    = ex_q.rdata2;
  assign bus.imm_ex       = ex_q.imm;
  assign bus.pc_ex        = ex_q.pc;
  assign bus.stall_id     = stall_s;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Bubble counters; a flush that coincides with a hazard counts only as a flush
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else if (!bus.hold && bus.flush_ex) begin
      flush_cnt_q <= flush_cnt_q + 32'd1;
    end else if (!bus.hold && haz_s) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
      flush_cnt_q <= flush_cnt_q;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed-vector bench for id_ex_hazard_reg; expected values are hand-computed.
// Counter checks are compiled in only when ID_EX_STALL_CNT_EN is defined.
module tb_id_ex_hazard_reg;
  logic clk;
  logic arst_n;
  int   n_vec;
  int   n_err;

  id_ex_hazard_reg_if #(.DATA_W(32), .CTRL_W(8)) bus ();

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  id_ex_hazard_reg #(.DATA_W(32), .CTRL_W(8)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .bus      (bus)
`ifdef ID_EX_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Data fields are derived from pc so every vector carries distinct payloads
  task automatic drv(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic u1, input logic u2,
                     input logic rw, input logic mr, input logic [31:0] pc);
    bus.valid_id     = v;
    bus.rs1_id       = r1;
    bus.rs2_id       = r2;
    bus.rd_id        = rd;
    bus.uses_rs1_id  = u1;
    bus.uses_rs2_id  = u2;
    bus.reg_write_id = rw;
    bus.mem_read_id  = mr;
    bus.ctrl_id      = pc[7:0] ^ 8'h5A;
    bus.rdata1_id    = pc ^ 32'hA5A5_0000;
    bus.rdata2_id    = ~pc;
    bus.imm_id       = pc + 32'd4;
    bus.pc_id        = pc;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.hold     = 1'b0;
    bus.flush_ex = 1'b0;
    arst_n       = 1'b0;
    drv(1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040);

    // Reset with arbitrary inputs
    tick();
    tick();
    chk("rst_valid", {31'd0, bus.valid_ex}, 32'd0);
    chk("rst_rd", {27'd0, bus.rd_ex}, 32'd0);
    chk("rst_memrd", {31'd0, bus.mem_read_ex}, 32'd0);
    chk("rst_ctrl", {24'd0, bus.ctrl_ex}, 32'd0);
    chk("rst_rdata1", bus.rdata1_ex, 32'd0);
    chk("rst_pc", bus.pc_ex, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_id}, 32'd0);

    // First load after release
    arst_n = 1'b1;
    drv(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100);
    tick();
    chk("ld_valid", {31'd0, bus.valid_ex}, 32'd1);
    chk("ld_rd", {27'd0, bus.rd_ex}, 32'd5);
    chk("ld_rw", {31'd0, bus.reg_write_ex}, 32'd1);
    chk("ld_ctrl", {24'd0, bus.ctrl_ex}, 32'h5A);
    chk("ld_rdata1", bus.rdata1_ex, 32'hA5A5_0100);
    chk("ld_rdata2", bus.rdata2_ex, 32'hFFFF_FEFF);
    chk("ld_pc", bus.pc_ex, 32'h0000_0100);

    // Load-use: lw x3 then add using x3
    drv(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0104);
    tick();
    chk("lw_memrd", {31'd0, bus.mem_read_ex}, 32'd1);
    drv(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0108);
    chk("lu_stall", {31'd0, bus.stall_id}, 32'd1);
    tick();
    chk("lu_bub_valid", {31'd0, bus.valid_ex}, 32'd0);
    chk("lu_bub_rd", {27'd0, bus.rd_ex}, 32'd0);
    chk("lu_bub_rw", {31'd0, bus.reg_write_ex}, 32'd0);
    chk("lu_bub_stall", {31'd0, bus.stall_id}, 32'd0);
    tick();
    chk("lu_add_valid", {31'd0, bus.valid_ex}, 32'd1);
    chk("lu_add_rd", {27'd0, bus.rd_ex}, 32'd6);
    chk("lu_add_rs1", {27'd0, bus.rs1_ex}, 32'd3);
    chk("lu_add_imm", bus.imm_ex, 32'h0000_010C);

    // Load to x0 never stalls
    drv(1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_010C);
    tick();
    drv(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0110);
    chk("x0_nostall", {31'd0, bus.stall_id}, 32'd0);
    tick();
    // Now lw x9 in EX
    drv(1'b1, 5'd1, 5'd9, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0114);
    chk("rs2_unused", {31'd0, bus.stall_id}, 32'd0);
    drv(1'b0, 5'd9, 5'd9, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0114);
    chk("id_invalid", {31'd0, bus.stall_id}, 32'd0);
    drv(1'b1, 5'd1, 5'd9, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0114);
    chk("rs2_stall", {31'd0, bus.stall_id}, 32'd1);

    // Flush beats stall, then a second consecutive flush
    bus.flush_ex = 1'b1;
    #1;
    chk("fl_nostall", {31'd0, bus.stall_id}, 32'd0);
    tick();
    chk("fl_valid", {31'd0, bus.valid_ex}, 32'd0);
    chk("fl_rs2", {27'd0, bus.rs2_ex}, 32'd0);
    chk("fl_memrd", {31'd0, bus.mem_read_ex}, 32'd0);
    drv(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0118);
    tick();
    chk("fl2_valid", {31'd0, bus.valid_ex}, 32'd0);
    chk("fl2_rd", {27'd0, bus.rd_ex}, 32'd0);
`ifdef ID_EX_STALL_CNT_EN
    chk("cnt_stall_a", stall_cnt, 32'd1);
    chk("cnt_flush_a", flush_cnt, 32'd2);
`endif
    bus.flush_ex = 1'b0;

    // Hold freezes a lw x10 in EX despite changing inputs and a flush
    drv(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    tick();
    chk("hd_pre_rd", {27'd0, bus.rd_ex}, 32'd10);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 5'd10, 5'd10, 5'(20 + i), 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0204 + 32'(4 * i));
      bus.flush_ex = (i == 1);
      #1;
      chk("hd_stall", {31'd0, bus.stall_id}, 32'd0);
      tick();
      chk("hd_rd", {27'd0, bus.rd_ex}, 32'd10);
      chk("hd_pc", bus.pc_ex, 32'h0000_0200);
      chk("hd_valid", {31'd0, bus.valid_ex}, 32'd1);
    end
    bus.hold     = 1'b0;
    bus.flush_ex = 1'b0;
    drv(1'b1, 5'd2, 5'd3, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0300);
    tick();
    chk("hd_rel_rd", {27'd0, bus.rd_ex}, 32'd11);
    chk("hd_rel_pc", bus.pc_ex, 32'h0000_0300);

    // Invalid ID instruction loads with control forced off
    drv(1'b0, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0400);
    tick();
    chk("inv_valid", {31'd0, bus.valid_ex}, 32'd0);
    chk("inv_rd", {27'd0, bus.rd_ex}, 32'd0);
    chk("inv_rw", {31'd0, bus.reg_write_ex}, 32'd0);
    chk("inv_memrd", {31'd0, bus.mem_read_ex}, 32'd0);

    // Reset asserted mid-stall
    drv(1'b1, 5'd1, 5'd2, 5'd13, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0500);
    tick();
    drv(1'b1, 5'd13, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0504);
    chk("mr_stall", {31'd0, bus.stall_id}, 32'd1);
    arst_n = 1'b0;
    tick();
    chk("mr_valid", {31'd0, bus.valid_ex}, 32'd0);
    chk("mr_rd", {27'd0, bus.rd_ex}, 32'd0);
    chk("mr_nostall", {31'd0, bus.stall_id}, 32'd0);
    arst_n = 1'b1;

    // Load followed by dependent load
    drv(1'b1, 5'd1, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0600);
    tick();
    drv(1'b1, 5'd14, 5'd0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0604);
    chk("ll_stall", {31'd0, bus.stall_id}, 32'd1);
    tick();
    chk("ll_bub", {31'd0, bus.valid_ex}, 32'd0);
    chk("ll_nostall", {31'd0, bus.stall_id}, 32'd0);
    tick();
    chk("ll_rd", {27'd0, bus.rd_ex}, 32'd15);
    chk("ll_memrd", {31'd0, bus.mem_read_ex}, 32'd1);
    chk("ll_pc", bus.pc_ex, 32'h0000_0604);
`ifdef ID_EX_STALL_CNT_EN
    chk("cnt_stall_b", stall_cnt, 32'd1);
    chk("cnt_flush_b", flush_cnt, 32'd0);
    // Counter wrap on the next load-use bubble
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    drv(1'b1, 5'd15, 5'd0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0608);
    tick();
    chk("cnt_wrap", stall_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register for the 5-stage RISC-V core, with integrated load-use hazard detection and bubble/flush insertion.
- Its registered rs1_ex, rs2_ex, rd_ex and reg_write_ex outputs feed the EX-stage forwarding logic and the EX/MEM register.
- The combinational stall_id output freezes the PC and the IF/ID register when a load-use hazard exists.

Parameters:
- DATA_W, 32, width of the register-file operands, immediate and PC.
- CTRL_W, 8, width of the opaque EX/MEM/WB control bundle (ALU op, alu_src, branch, jump, mem_write, mem_2_reg).

Ports:
- clk  in  1  core clock, rising edge.
- arst_n  in  1  reset, synchronous, active-low.
- valid_id  in  1  ID holds a real instruction.
- rs1_id  in  5  source register 1 index.
- rs2_id  in  5  source register 2 index.
- rd_id  in  5  destination register index.
- uses_rs1_id  in  1  instruction reads rs1.
- uses_rs2_id  in  1  instruction reads rs2.
- reg_write_id  in  1  instruction writes rd.
- mem_read_id  in  1  instruction is a load.
- ctrl_id  in  CTRL_W  remaining control bundle.
- rdata1_id  in  DATA_W  register-file read data 1.
- rdata2_id  in  DATA_W  register-file read data 2.
- imm_id  in  DATA_W  immediate.
- pc_id  in  DATA_W  instruction PC.
- hold  in  1  global freeze (e.g. memory wait).
- flush_ex  in  1  taken branch/jump resolved in EX; squash the ID instruction.
- valid_ex, rs1_ex, rs2_ex, rd_ex, reg_write_ex, mem_read_ex, ctrl_ex, rdata1_ex, rdata2_ex, imm_ex, pc_ex  out  (widths as the ID counterparts)  registered EX-stage copies.
- stall_id  out  1  combinational; hold PC and IF/ID this cycle.

Behaviour:
- Reset (arst_n=0 at a rising edge): every registered output is 0. stall_id is 0 whenever all registers hold reset values.
- Hazard term: haz = valid_ex & mem_read_ex & (rd_ex!=0) & valid_id & ((uses_rs1_id & rs1_id==rd_ex) | (uses_rs2_id & rs2_id==rd_ex)).
- stall_id = haz & ~flush_ex & ~hold.
- Per-edge update, in priority order:
  1. Reset.
  2. hold=1: all registers keep their values; flush_ex is ignored this cycle, and the EX stage, being frozen, re-presents it.
  3. flush_ex=1: insert bubble.
  4. haz=1: insert bubble.
  5. Otherwise: load all *_ex from *_id, with valid_ex = valid_id.
- Bubble:
  - valid_ex, reg_write_ex, mem_read_ex and ctrl_ex are all 0.
  - rd_ex, rs1_ex and rs2_ex are 0, so forwarding never matches a bubble.
  - Data fields (rdata*, imm, pc) are don't-care; the implementation zeroes them.
- Load with valid_id=0: reg_write_ex and mem_read_ex are 0 and rd_ex is 0, regardless of the ID control inputs.
- Latency: one cycle from ID inputs to EX outputs.
- One load-use hazard yields exactly one bubble. On the next cycle the load is in MEM, haz drops, and the stalled instruction loads.
- rd_ex=0 never triggers a stall (a load to x0).
- A load followed by a dependent load stalls the same as any other dependency.
- Back-to-back flush_ex cycles produce consecutive bubbles.
- Reset asserted mid-stall clears everything. stall_id drops on the next cycle.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- When defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - Each is cleared by reset, increments on every edge where a haz bubble or flush bubble respectively is inserted (hold=0), and wraps from 0xFFFFFFFF to 0.
  - When flush and haz occur together, only flush_cnt increments.
- When undefined: the ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
- Reset: drive arst_n=0 for 2 cycles with arbitrary inputs -> all outputs 0 and stall_id=0; after release with valid_id=1, rd_id=5, reg_write_id=1 -> next cycle rd_ex=5, valid_ex=1.
- Load-use: lw x3 in EX (mem_read_ex=1, rd_ex=3); ID add with rs1=3, uses_rs1=1 -> stall_id=1 that cycle; next cycle valid_ex=0 and rd_ex=0; following cycle stall_id=0 and the add loads.
- No false stall: rd_ex=0 load with rs1_id=0 -> stall_id=0. Dependency on rs2 with uses_rs2_id=0 -> stall_id=0.
- Flush beats stall: haz condition true and flush_ex=1 -> stall_id=0; next cycle bubble; with ID_EX_STALL_CNT_EN, flush_cnt=1 and stall_cnt=0.
- Hold: hold=1 for 3 cycles with changing ID inputs -> all *_ex unchanged and stall_id=0; on release the current ID inputs load.
- Counter wrap (ID_EX_STALL_CNT_EN): force stall_cnt to 0xFFFFFFFF, then one load-use bubble -> stall_cnt=0.
